// File: rtl/gate_identifier.sv
// rtl/gate_identifier.sv - identifies which 2-input bitwise gate produced observed samples
module gate_identifier #(
    parameter int MAX_SAMPLES = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       sample_valid,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] y,
    output logic       sample_ready,
    output logic       done,
    output logic [2:0] gate_id,
    output logic [4:0] candidates,
    output logic       error,
    output logic [3:0] sample_count
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_SAMPLES);
    localparam logic [2:0] GATE_NONE = 3'd7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] cand_q, cand_d;
    logic [3:0] count_q, count_d;
    logic [2:0] gate_q, gate_d;
    logic       err_q, err_d;

    logic [4:0] match;
    logic [4:0] new_mask;
    logic [3:0] new_count;
    logic       new_onehot;
    logic [2:0] new_idx;

    // Per-sample match vector: a gate survives only if all four result bits agree.
    always_comb begin
        match[0] = (y == (a & b));
        match[1] = (y == (a | b));
        match[2] = (y == (a ^ b));
        match[3] = (y == ~(a & b));
        match[4] = (y == ~(a | b));
    end

    // Candidate mask after accepting the current sample, and its single set bit if any.
    always_comb begin
        new_mask   = cand_q & match;
        new_count  = count_q + 4'd1;
        new_onehot = (new_mask != 5'd0) && ((new_mask & (new_mask - 5'd1)) == 5'd0);
        new_idx    = 3'd0;
        for (int i = 0; i < 5; i++) begin
            if (new_mask[i]) begin
                new_idx = 3'(i);
            end
        end
    end

    // Next-state and output logic; start always wins over a simultaneous sample.
    always_comb begin
        state_d      = state_q;
        cand_d       = cand_q;
        count_d      = count_q;
        gate_d       = gate_q;
        err_d        = err_q;
        sample_ready = 1'b0;
        done         = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = COLLECT;
                    cand_d  = 5'b11111;
                    count_d = 4'd0;
                    gate_d  = GATE_NONE;
                    err_d   = 1'b0;
                end
            end
            COLLECT: begin
                sample_ready = 1'b1;
                if (start) begin
                    cand_d  = 5'b11111;
                    count_d = 4'd0;
                    gate_d  = GATE_NONE;
                    err_d   = 1'b0;
                end else if (sample_valid) begin
                    cand_d  = new_mask;
                    count_d = new_count;
                    if (new_onehot) begin
                        state_d = DONE;
                        gate_d  = new_idx;
                        err_d   = 1'b0;
                    end else if (new_mask == 5'd0) begin
                        state_d = DONE;
                        gate_d  = GATE_NONE;
                        err_d   = 1'b1;
                    end else if (new_count >= MAX_CNT) begin
                        state_d = DONE;
                        gate_d  = GATE_NONE;
                        err_d   = 1'b0;
                    end
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    state_d = COLLECT;
                    cand_d  = 5'b11111;
                    count_d = 4'd0;
                    gate_d  = GATE_NONE;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cand_q  <= 5'b11111;
            count_q <= 4'd0;
            gate_q  <= GATE_NONE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            count_q <= count_d;
            gate_q  <= gate_d;
            err_q   <= err_d;
        end
    end

    assign candidates   = cand_q;
    assign sample_count = count_q;
    assign gate_id      = gate_q;
    assign error        = err_q;

endmodule
